// File: rtl/stage_controller_pkg.sv
// Shared architecture encodings for the stage controller: stage numbers, ALU opcodes and the memory stall limit.
package stage_controller_pkg;

  typedef enum logic [2:0] {
    STAGE_INST_FETCH = 3'd0,
    STAGE_REG_READ   = 3'd1,
    STAGE_EXECUTE    = 3'd2,
    STAGE_MEM        = 3'd3,
    STAGE_REG_UPDATE = 3'd4,
    STAGE_PC_UPDATE  = 3'd5,
    STAGE_HALTED     = 3'd6
  } stage_e;

  localparam logic [4:0] ALU_OP_ADD = 5'd0;
  localparam logic [4:0] ALU_OP_SUB = 5'd1;
  localparam logic [4:0] ALU_OP_AND = 5'd2;
  localparam logic [4:0] ALU_OP_OR  = 5'd3;
  localparam logic [4:0] ALU_OP_XOR = 5'd4;
  localparam logic [4:0] ALU_OP_SLT = 5'd5;
  localparam logic [4:0] ALU_OP_SHL = 5'd6;
  localparam logic [4:0] ALU_OP_SHR = 5'd7;
  localparam logic [4:0] ALU_OP_MUL = 5'd8;

  localparam int STALL_LIMIT = 15;
  localparam int STALL_W     = 4;

  function automatic logic is_mem_wait(stage_e s);
    return (s == STAGE_INST_FETCH) || (s == STAGE_MEM);
  endfunction

endpackage

// File: rtl/stage_controller_if.sv
// Decode/memory/multiplier handshake bundle between the stage controller (master) and the datapath (slave).
interface stage_controller_if;
  logic [4:0] alu_operation;
  logic       inst_is_load;
  logic       inst_is_store;
  logic       inst_is_halt;
  logic       mem_ready;
  logic       mul_done;
  logic [2:0] stage;
  logic       mem_read_en;
  logic       mem_write_en;
  logic       reg_write_en;
  logic       pc_write_en;
  logic       mul_start;
  logic       timeout_err;

  modport master (
    input  alu_operation, inst_is_load, inst_is_store, inst_is_halt, mem_ready, mul_done,
    output stage, mem_read_en, mem_write_en, reg_write_en, pc_write_en, mul_start, timeout_err
  );

  modport slave (
    output alu_operation, inst_is_load, inst_is_store, inst_is_halt, mem_ready, mul_done,
    input  stage, mem_read_en, mem_write_en, reg_write_en, pc_write_en, mul_start, timeout_err
  );
endinterface

// File: rtl/stage_controller_stall_timer.sv
// Memory stall counter: counts cycles waited in a memory stage and flags when the stall limit is reached.
module stall_timer
  import stage_controller_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  logic [STALL_W-1:0] r_count;

  // Saturates at the limit; the controller leaves the wait stage on that same edge anyway.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_count <= '0;
    end else if (count_en && !expired) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign expired = (r_count == STALL_W'(STALL_LIMIT));

endmodule

// File: rtl/stage_controller.sv
// Multi-cycle instruction stage sequencer with memory stall timeout.
// Optional MULTIPLIER_EN: EXECUTE waits for mul_done on ALU_OP_MUL after a one-cycle mul_start pulse.
module stage_controller
  import stage_controller_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  stage_controller_if.master bus
);

  stage_e r_state;
  stage_e w_state_next;
  logic   r_timeout_err;
  logic   w_timeout_set;
  logic   w_wait_stage;
  logic   w_expired;
  logic   w_mul_busy;
  logic   w_mul_start;

  assign w_wait_stage = is_mem_wait(r_state);

  stall_timer u_stall_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (!w_wait_stage),
    .count_en (w_wait_stage && !bus.mem_ready),
    .expired  (w_expired)
  );

`ifdef MULTIPLIER_EN
  logic r_mul_wait;
  logic w_is_mul;

  // mul_done only counts once the start pulse has gone out, so a stale done cannot end a new multiply.
  assign w_is_mul    = (r_state == STAGE_EXECUTE) && (bus.alu_operation == ALU_OP_MUL);
  assign w_mul_start = w_is_mul && !r_mul_wait;
  assign w_mul_busy  = w_is_mul && !(r_mul_wait && bus.mul_done);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mul_wait <= 1'b0;
    end else begin
      r_mul_wait <= w_mul_busy;
    end
  end
`else
  assign w_mul_start = 1'b0;
  assign w_mul_busy  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= STAGE_INST_FETCH;
      r_timeout_err <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_timeout_set) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_timeout_set = 1'b0;
    case (r_state)
      STAGE_INST_FETCH: begin
        if (bus.mem_ready) begin
          w_state_next = STAGE_REG_READ;
        end else if (w_expired) begin
          w_state_next  = STAGE_HALTED;
          w_timeout_set = 1'b1;
        end
      end
      STAGE_REG_READ: w_state_next = STAGE_EXECUTE;
      STAGE_EXECUTE: begin
        if (!w_mul_busy) begin
          if (bus.inst_is_halt) begin
            w_state_next = STAGE_HALTED;
          end else if (bus.inst_is_load || bus.inst_is_store) begin
            w_state_next = STAGE_MEM;
          end else begin
            w_state_next = STAGE_REG_UPDATE;
          end
        end
      end
      STAGE_MEM: begin
        if (bus.mem_ready) begin
          w_state_next = bus.inst_is_load ? STAGE_REG_UPDATE : STAGE_PC_UPDATE;
        end else if (w_expired) begin
          w_state_next  = STAGE_HALTED;
          w_timeout_set = 1'b1;
        end
      end
      STAGE_REG_UPDATE: w_state_next = STAGE_PC_UPDATE;
      STAGE_PC_UPDATE:  w_state_next = STAGE_INST_FETCH;
      STAGE_HALTED:     w_state_next = STAGE_HALTED;
      default:          w_state_next = STAGE_INST_FETCH;
    endcase
  end

  assign bus.stage        = r_state;
  assign bus.mem_read_en  = (r_state == STAGE_INST_FETCH) ||
                            ((r_state == STAGE_MEM) && bus.inst_is_load);
  assign bus.mem_write_en = (r_state == STAGE_MEM) && bus.inst_is_store && !bus.inst_is_load;
  assign bus.reg_write_en = (r_state == STAGE_REG_UPDATE);
  assign bus.pc_write_en  = (r_state == STAGE_PC_UPDATE);
  assign bus.mul_start    = w_mul_start;
  assign bus.timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_stage_controller.sv
// Self-checking bench for stage_controller: per-instruction cycle plans from the stage rules, checked every cycle.
module tb_stage_controller;
  import stage_controller_pkg::*;

`ifdef MULTIPLIER_EN
  localparam int MUL_EN = 1;
`else
  localparam int MUL_EN = 0;
`endif

  localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_MUL = 3, K_HALT = 4, K_ABORT = 5;

  typedef struct {
    bit       chk;
    int       stage;
    int       rd, wr, rw, pw, ms, te;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  stage_controller_if ifc ();

  stage_controller dut (.clk(clk), .rst(rst), .bus(ifc));

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_instr  = 0;
  int   m_te     = 0;
  exp_t exp_q[$];
  int   obs_stage[$];
  int   obs_te[$];

  function automatic void check(string nm, logic [31:0] act, int expv);
    n_checks++;
    if (act !== 32'(expv)) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, expv, $time);
    end
  endfunction

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Single compare process: every planned cycle is checked on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        obs_stage.push_back(int'(ifc.stage));
        obs_te.push_back(int'(ifc.timeout_err));
        if (e.chk) begin
          check("stage",        32'(ifc.stage),        e.stage);
          check("mem_read_en",  32'(ifc.mem_read_en),  e.rd);
          check("mem_write_en", 32'(ifc.mem_write_en), e.wr);
          check("reg_write_en", 32'(ifc.reg_write_en), e.rw);
          check("pc_write_en",  32'(ifc.pc_write_en),  e.pw);
          check("mul_start",    32'(ifc.mul_start),    e.ms);
          check("timeout_err",  32'(ifc.timeout_err),  e.te);
        end
      end
    end
  end

  task automatic step(input int st, input bit rdy, input bit mdone, input int ms, input bit chk);
    exp_t e;
    ifc.mem_ready = rdy;
    ifc.mul_done  = mdone;
    e.chk   = chk;
    e.stage = st;
    e.rd    = int'((st == 0) || (st == 3 && ifc.inst_is_load));
    e.wr    = int'(st == 3 && ifc.inst_is_store);
    e.rw    = int'(st == 4);
    e.pw    = int'(st == 5);
    e.ms    = ms;
    e.te    = m_te;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Memory wait: ready arrives on cycle waits+1; 16 cycles without it is a timeout.
  task automatic wait_phase(input int st, input int waits, output bit timed_out);
    timed_out = 1'b0;
    for (int c = 0; c < 16; c++) begin
      step(st, c == waits, rb(), 0, 1'b1);
      if (c == waits) return;
    end
    timed_out = 1'b1;
    m_te      = 1;
  endtask

  task automatic do_reset(input int st, input int ms);
    rst = 1'b1;
    step(st, rb(), rb(), ms, 1'b1);
    rst  = 1'b0;
    m_te = 0;
  endtask

  task automatic halt_tail();
    int n;
    n = $urandom_range(2, 5);
    for (int i = 0; i < n; i++) step(6, rb(), rb(), 0, 1'b1);
    do_reset(6, 0);
  endtask

  task automatic run_instr(input int kind, input int fw, input int mw, input int md);
    bit to;
    ifc.alu_operation = (kind == K_MUL || kind == K_ABORT) ? ALU_OP_MUL : 5'($urandom_range(0, 7));
    ifc.inst_is_load  = (kind == K_LOAD);
    ifc.inst_is_store = (kind == K_STORE);
    ifc.inst_is_halt  = (kind == K_HALT);
    $display("instr %0d kind=%0d fetch_waits=%0d mem_waits=%0d mul_delay=%0d t=%0t",
             n_instr, kind, fw, mw, md, $time);
    n_instr++;
    wait_phase(0, fw, to);
    if (to) begin
      halt_tail();
      return;
    end
    step(1, rb(), rb(), 0, 1'b1);
    if (kind == K_ABORT) begin
      do_reset(2, MUL_EN);
      return;
    end
    if (kind == K_MUL && MUL_EN == 1) begin
      for (int c = 0; c <= md; c++) step(2, rb(), c == md, int'(c == 0), 1'b1);
    end else begin
      step(2, rb(), rb(), 0, 1'b1);
    end
    if (kind == K_HALT) begin
      halt_tail();
    end else if (kind == K_LOAD || kind == K_STORE) begin
      wait_phase(3, mw, to);
      if (to) begin
        halt_tail();
        return;
      end
      if (kind == K_LOAD) step(4, rb(), rb(), 0, 1'b1);
      step(5, rb(), rb(), 0, 1'b1);
    end else begin
      step(4, rb(), rb(), 0, 1'b1);
      step(5, rb(), rb(), 0, 1'b1);
    end
  endtask

  task automatic check_seq(input string nm, input int expv[$]);
    for (int i = 0; i < expv.size(); i++) begin
      if (i < obs_stage.size()) check(nm, 32'(obs_stage[i]), expv[i]);
      else check({nm, "_len"}, 32'(obs_stage.size()), expv.size());
    end
  endtask

  function automatic int pick_wait();
    if ($urandom_range(0, 7) == 0) return $urandom_range(14, 17);
    return $urandom_range(0, 4);
  endfunction

  initial begin
    int sq[$];
    int r, kind;
    ifc.alu_operation = ALU_OP_ADD;
    ifc.inst_is_load  = 1'b0;
    ifc.inst_is_store = 1'b0;
    ifc.inst_is_halt  = 1'b0;
    ifc.mem_ready     = 1'b0;
    ifc.mul_done      = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state, pinned by literals.
    check("rst_stage", 32'(ifc.stage), 0);
    check("rst_rd", 32'(ifc.mem_read_en), 1);
    check("rst_wr", 32'(ifc.mem_write_en), 0);
    check("rst_rw", 32'(ifc.reg_write_en), 0);
    check("rst_pw", 32'(ifc.pc_write_en), 0);
    check("rst_ms", 32'(ifc.mul_start), 0);
    check("rst_te", 32'(ifc.timeout_err), 0);

    obs_stage.delete(); obs_te.delete();
    run_instr(K_ALU, 0, 0, 0);
    sq = '{0, 1, 2, 4, 5};
    check_seq("seq_add", sq);
    check("add_wrap", 32'(ifc.stage), 0);

    obs_stage.delete(); obs_te.delete();
    run_instr(K_LOAD, 3, 2, 0);
    sq = '{0, 0, 0, 0, 1, 2, 3, 3, 3, 4, 5};
    check_seq("seq_load", sq);

    obs_stage.delete(); obs_te.delete();
    run_instr(K_STORE, 0, 0, 0);
    sq = '{0, 1, 2, 3, 5};
    check_seq("seq_store", sq);

    obs_stage.delete(); obs_te.delete();
    run_instr(K_MUL, 0, 0, 4);
    if (MUL_EN == 1) sq = '{0, 1, 2, 2, 2, 2, 2, 4, 5};
    else sq = '{0, 1, 2, 4, 5};
    check_seq("seq_mul", sq);

    obs_stage.delete(); obs_te.delete();
    run_instr(K_ALU, 15, 0, 0);
    sq = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    check_seq("seq_ready_at_limit", sq);
    check("limit_te", 32'(obs_te[16]), 0);

    obs_stage.delete(); obs_te.delete();
    run_instr(K_ALU, 16, 0, 0);
    sq = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6, 6};
    check_seq("seq_timeout", sq);
    check("timeout_te", 32'(obs_te[16]), 1);
    check("timeout_post_rst_te", 32'(ifc.timeout_err), 0);

    obs_stage.delete(); obs_te.delete();
    run_instr(K_HALT, 0, 0, 0);
    sq = '{0, 1, 2, 6, 6};
    check_seq("seq_halt", sq);
    check("halt_post_rst_stage", 32'(ifc.stage), 0);
    check("halt_post_rst_te", 32'(ifc.timeout_err), 0);

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 2) kind = K_ALU;
      else if (r <= 4) kind = K_LOAD;
      else if (r <= 6) kind = K_STORE;
      else if (r == 7) kind = K_MUL;
      else if (r == 8) kind = K_HALT;
      else kind = K_ABORT;
      run_instr(kind, pick_wait(), pick_wait(), $urandom_range(1, 6));
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
